// File: rtl/i2c_slave_regif.sv
// I2C slave with an auto-incrementing register pointer, fully in the CLK domain.
// SCL/SDA are synchronised, deglitched and edge-detected; the bus drives a single-cycle register port.
module i2c_slave_regif #(
    parameter int REG_AW     = 8,
    parameter int FILTER_LEN = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCL,
    inout  wire               SDA,
    input  logic [6:0]        S_ADDR,
    output logic [6:0]        ADDR,
    output logic [REG_AW-1:0] REG_ADDR,
    output logic [7:0]        REG_WDATA,
    output logic              REG_WE,
    output logic              REG_RE,
    input  logic [7:0]        REG_RDATA,
    output logic              BUSY
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ACK_A, ST_PTR, ST_ACK_P,
        ST_WR_DATA, ST_ACK_W, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic [1:0] w_filt_d;

    // Channel 1 is SCL, channel 0 is SDA; both idle high out of reset.
    assign w_raw = {SCL, SDA};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_in
            logic [1:0] r_sync;
            logic [3:0] r_cnt;
            logic       r_filt;
            logic       r_filt_d;
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_sync   <= 2'b11;
                    r_cnt    <= '0;
                    r_filt   <= 1'b1;
                    r_filt_d <= 1'b1;
                end else begin
                    r_sync   <= {r_sync[0], w_raw[gi]};
                    r_filt_d <= r_filt;
                    if (r_sync[1] == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
                        r_filt <= r_sync[1];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
            end
            assign w_filt[gi]   = r_filt;
            assign w_filt_d[gi] = r_filt_d;
        end
    endgenerate

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl      = w_filt[1];
    assign w_sda      = w_filt[0];
    assign w_scl_rise = w_scl & ~w_filt_d[1];
    assign w_scl_fall = ~w_scl & w_filt_d[1];
    assign w_start    = w_scl & w_filt_d[1] & w_filt_d[0] & ~w_sda;
    assign w_stop     = w_scl & w_filt_d[1] & ~w_filt_d[0] & w_sda;

    state_t            r_state, w_state_next;
    logic [3:0]        r_cnt, w_cnt_next;
    logic [7:0]        r_shift, w_shift_next;
    logic              r_oe, w_oe_next;
    logic              r_rw, w_rw_next;
    logic              r_mack, w_mack_next;
    logic              r_rd_load;
    logic [6:0]        r_addr, w_addr_next;
    logic [REG_AW-1:0] r_ptr, w_ptr_next;
    logic [7:0]        r_wdata, w_wdata_next;
    logic              r_we, w_we_next;
    logic              r_re, w_re_next;
    logic              r_busy, w_busy_next;
    logic [7:0]        w_byte;

    assign w_byte = {r_shift[6:0], w_sda};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_oe      <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b0;
            r_rd_load <= 1'b0;
            r_addr    <= '0;
            r_ptr     <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_shift   <= w_shift_next;
            r_oe      <= w_oe_next;
            r_rw      <= w_rw_next;
            r_mack    <= w_mack_next;
            r_rd_load <= r_re;
            r_addr    <= w_addr_next;
            r_ptr     <= w_ptr_next;
            r_wdata   <= w_wdata_next;
            r_we      <= w_we_next;
            r_re      <= w_re_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_oe_next    = r_oe;
        w_rw_next    = r_rw;
        w_mack_next  = r_mack;
        w_addr_next  = r_addr;
        w_ptr_next   = r_ptr;
        w_wdata_next = r_wdata;
        w_we_next    = 1'b0;
        w_re_next    = 1'b0;
        w_busy_next  = r_busy;
        if (w_start) begin
            w_state_next = ST_ADDR;
            w_cnt_next   = '0;
            w_oe_next    = 1'b0;
            w_busy_next  = 1'b0;
        end else if (w_stop) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_oe_next    = 1'b0;
            w_busy_next  = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_next = w_byte;
                        w_cnt_next   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_cnt_next = '0;
                            if (r_state == ST_ADDR) begin
                                w_addr_next = r_shift[6:0];
                                w_rw_next   = w_sda;
                                if (r_shift[6:0] == S_ADDR) begin
                                    w_busy_next  = 1'b1;
                                    w_state_next = ST_ACK_A;
                                end else begin
                                    w_state_next = ST_WAIT_STOP;
                                end
                            end else if (r_state == ST_PTR) begin
                                w_ptr_next   = w_byte[REG_AW-1:0];
                                w_state_next = ST_ACK_P;
                            end else begin
                                w_wdata_next = w_byte;
                                w_we_next    = 1'b1;
                                w_state_next = ST_ACK_W;
                            end
                        end
                    end
                end
                // r_cnt marks whether the ACK slot has started driving yet.
                ST_ACK_A, ST_ACK_P, ST_ACK_W: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd0) begin
                            w_oe_next  = 1'b1;
                            w_cnt_next = 4'd1;
                        end else begin
                            w_oe_next  = 1'b0;
                            w_cnt_next = '0;
                            if (r_state == ST_ACK_A) begin
                                if (r_rw) begin
                                    w_re_next    = 1'b1;
                                    w_state_next = ST_RD_DATA;
                                end else begin
                                    w_state_next = ST_PTR;
                                end
                            end else begin
                                if (r_state == ST_ACK_W) w_ptr_next = r_ptr + 1'b1;
                                w_state_next = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (r_rd_load) begin
                        w_shift_next = REG_RDATA;
                        w_oe_next    = ~REG_RDATA[7];
                    end else if (w_scl_rise) begin
                        w_cnt_next = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe_next    = 1'b0;
                            w_cnt_next   = '0;
                            w_state_next = ST_RD_ACK;
                        end else begin
                            w_shift_next = {r_shift[6:0], 1'b0};
                            w_oe_next    = ~r_shift[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_next = w_sda;
                        w_cnt_next  = 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd1) begin
                        w_ptr_next = r_ptr + 1'b1;
                        w_cnt_next = '0;
                        if (!r_mack) begin
                            w_re_next    = 1'b1;
                            w_state_next = ST_RD_DATA;
                        end else begin
                            w_busy_next  = 1'b0;
                            w_state_next = ST_WAIT_STOP;
                        end
                    end
                end
                ST_IDLE, ST_WAIT_STOP: ;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign SDA       = r_oe ? 1'b0 : 1'bz;
    assign ADDR      = r_addr;
    assign REG_ADDR  = r_ptr;
    assign REG_WDATA = r_wdata;
    assign REG_WE    = r_we;
    assign REG_RE    = r_re;
    assign BUSY      = r_busy;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bench for i2c_slave_regif: bit-banged I2C master, register bank, and a transaction-level
// model of pointer/bank behaviour checked against the register port every cycle.
module tb_i2c_slave_regif;
    localparam int Q = 8;
    localparam int H = 16;
    localparam logic [6:0] SLV = 7'h42;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       glitch_en = 1'b0;
    logic       bank_init = 1'b1;
    wire        sda_bus;
    logic [6:0] s_addr = SLV;
    logic [6:0] addr_o;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    int checks = 0;
    int errors = 0;
    logic [7:0]  m_bank [256];
    logic [7:0]  hw_bank [256];
    logic [7:0]  m_ptr = 8'h00;
    logic [6:0]  m_addr = 7'h00;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_re [$];
    logic [7:0]  got_rd [$];

    always #5 clk = ~clk;
    pullup (sda_bus);
    assign sda_bus = m_sda ? 1'bz : 1'b0;

    i2c_slave_regif #(.REG_AW(8), .FILTER_LEN(3)) dut (
        .CLK(clk), .RST(rst), .SCL(scl), .SDA(sda_bus), .S_ADDR(s_addr),
        .ADDR(addr_o), .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata),
        .REG_WE(reg_we), .REG_RE(reg_re), .REG_RDATA(reg_rdata), .BUSY(busy)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 29 + 91) & 255);
    endfunction

    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 256; i++) hw_bank[i] <= init_val(i);
        end else if (reg_we) begin
            hw_bank[reg_addr] <= reg_wdata;
        end
        if (reg_re) reg_rdata <= hw_bank[reg_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic monitor();
        logic [15:0] w;
        logic [7:0]  r;
        forever begin
            @(negedge clk);
            if (!rst && reg_we) begin
                check("we_expected", 32'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    check("we_addr_data", {reg_addr, reg_wdata}, w);
                end
            end
            if (!rst && reg_re) begin
                check("re_expected", 32'(exp_re.size() > 0), 1);
                if (exp_re.size() > 0) begin
                    r = exp_re.pop_front();
                    check("re_addr", reg_addr, r);
                end
            end
        end
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(H);
        m_sda = 1'b0; wait_clk(H);
        scl = 1'b0;   wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q);
        scl = 1'b1;   wait_clk(H);
        m_sda = 1'b1; wait_clk(H);
    endtask

    task automatic bus_bit(input logic b, output logic rd);
        m_sda = b; wait_clk(Q);
        scl = 1'b1; wait_clk(H / 2);
        rd = sda_bus;
        if (glitch_en) begin
            m_sda = ~b; wait_clk(1);
            m_sda = b;  wait_clk(H / 2 - 1);
        end else begin
            wait_clk(H / 2);
        end
        scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string name);
        logic rd;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], rd);
        bus_bit(1'b1, rd);
        check(name, rd, exp_ack);
    endtask

    task automatic recv_byte(input logic nack, input logic [7:0] exp);
        logic rd;
        logic [7:0] v;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, rd);
            v[i] = rd;
        end
        got_rd.push_back(v);
        check("rd_byte", v, exp);
        bus_bit(nack, rd);
    endtask

    task automatic end_checks();
        check("busy_idle", busy, 0);
        check("reg_addr", reg_addr, m_ptr);
        check("addr_mon", addr_o, m_addr);
        check("we_left", exp_wr.size(), 0);
        check("re_left", exp_re.size(), 0);
    endtask

    task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input logic [7:0] data[$]);
        logic match;
        match = (a == SLV);
        $display("txn write addr=%h ptr=%h bytes=%0d match=%0d", a, p, data.size(), match);
        bus_start();
        m_addr = a;
        send_byte({a, 1'b0}, !match, "ack_addr_w");
        check("busy_after_addr", busy, match);
        send_byte(p, !match, "ack_ptr");
        if (match) m_ptr = p;
        foreach (data[i]) begin
            if (match) begin
                exp_wr.push_back({m_ptr, data[i]});
                m_bank[m_ptr] = data[i];
                m_ptr++;
            end
            send_byte(data[i], !match, "ack_data");
        end
        bus_stop();
        end_checks();
    endtask

    task automatic read_txn(input logic [6:0] a, input logic set_ptr, input logic [7:0] p, input int n);
        logic match;
        match = (a == SLV);
        $display("txn read addr=%h set_ptr=%0d ptr=%h bytes=%0d match=%0d", a, set_ptr, p, n, match);
        got_rd.delete();
        bus_start();
        if (set_ptr) begin
            m_addr = a;
            send_byte({a, 1'b0}, !match, "ack_addr_p");
            send_byte(p, !match, "ack_ptr_r");
            if (match) m_ptr = p;
            bus_start();
        end
        m_addr = a;
        if (match) for (int i = 0; i < n; i++) exp_re.push_back(8'(m_ptr + 8'(i)));
        send_byte({a, 1'b1}, !match, "ack_addr_r");
        if (match) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(i == n - 1, m_bank[m_ptr]);
                m_ptr++;
            end
            check("busy_nack", busy, 0);
            check("sda_released", sda_bus, 1);
        end
        bus_stop();
        end_checks();
    endtask

    initial begin
        logic [7:0] data [$];
        logic [6:0] ra;
        logic [7:0] rp;
        logic       rd;
        int         rn;
        for (int i = 0; i < 256; i++) m_bank[i] = init_val(i);
        fork monitor(); join_none
        wait_clk(4);
        check("rst_busy", busy, 0);
        check("rst_we", reg_we, 0);
        check("rst_re", reg_re, 0);
        check("rst_ptr", reg_addr, 0);
        check("rst_addr", addr_o, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_sda", sda_bus, 1);
        rst = 1'b0;
        bank_init = 1'b0;
        wait_clk(10);

        data = '{8'hA5, 8'h5A};
        write_txn(SLV, 8'h10, data);
        check("burst_ptr_lit", reg_addr, 8'h12);
        check("burst_bank10_lit", hw_bank[8'h10], 8'hA5);
        check("burst_bank11_lit", hw_bank[8'h11], 8'h5A);

        data = '{8'h3C, 8'hC3};
        write_txn(SLV, 8'h20, data);
        read_txn(SLV, 1'b1, 8'h20, 2);
        check("rd0_lit", got_rd[0], 8'h3C);
        check("rd1_lit", got_rd[1], 8'hC3);
        check("rd_ptr_lit", reg_addr, 8'h22);

        data = '{8'hFF};
        write_txn(7'h43, 8'h10, data);
        check("mismatch_addr_lit", addr_o, 7'h43);
        check("mismatch_ptr_lit", reg_addr, 8'h22);

        data = '{8'h11, 8'h22};
        write_txn(SLV, 8'hFF, data);
        check("wrap_ptr_lit", reg_addr, 8'h01);
        check("wrap_bankff_lit", hw_bank[8'hFF], 8'h11);
        check("wrap_bank00_lit", hw_bank[8'h00], 8'h22);

        m_sda = 1'b0; wait_clk(1); m_sda = 1'b1; wait_clk(20);
        check("idle_glitch_busy", busy, 0);
        glitch_en = 1'b1;
        data = '{8'h96, 8'h69};
        write_txn(SLV, 8'h40, data);
        glitch_en = 1'b0;

        $display("txn abort-stop ptr=50 after 4 data bits");
        bus_start();
        send_byte({SLV, 1'b0}, 1'b0, "abort_ack_addr");
        send_byte(8'h50, 1'b0, "abort_ack_ptr");
        bus_bit(1'b1, rd); bus_bit(1'b0, rd); bus_bit(1'b1, rd); bus_bit(1'b1, rd);
        bus_stop();
        m_ptr = 8'h50;
        m_addr = SLV;
        end_checks();
        check("abort_ptr_lit", reg_addr, 8'h50);

        $display("txn abort-start ptr=60 after 3 data bits");
        bus_start();
        send_byte({SLV, 1'b0}, 1'b0, "sabort_ack_addr");
        send_byte(8'h60, 1'b0, "sabort_ack_ptr");
        bus_bit(1'b0, rd); bus_bit(1'b1, rd); bus_bit(1'b0, rd);
        m_ptr = 8'h60;
        data = '{8'h77};
        write_txn(SLV, 8'h61, data);

        data = '{8'h00};
        write_txn(SLV, 8'h30, data);
        $display("txn reset-mid-read ptr=30");
        bus_start();
        send_byte({SLV, 1'b0}, 1'b0, "rr_ack_addr");
        send_byte(8'h30, 1'b0, "rr_ack_ptr");
        bus_start();
        exp_re.push_back(8'h30);
        send_byte({SLV, 1'b1}, 1'b0, "rr_ack_addr_r");
        m_sda = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(4);
        check("rr_slave_low", sda_bus, 0);
        rst = 1'b1;
        wait_clk(1);
        check("rr_sda_released", sda_bus, 1);
        check("rr_busy", busy, 0);
        check("rr_ptr", reg_addr, 0);
        check("rr_addr", addr_o, 0);
        check("rr_wdata", reg_wdata, 0);
        check("rr_we_re", {reg_we, reg_re}, 0);
        wait_clk(3);
        rst = 1'b0;
        m_ptr = 8'h00;
        m_addr = 7'h00;
        wait_clk(Q);
        scl = 1'b0; wait_clk(Q);
        bus_stop();
        data = '{8'hE7};
        write_txn(SLV, 8'h05, data);

        for (int t = 0; t < 16; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
            rp = 8'($urandom);
            rn = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                data.delete();
                for (int i = 0; i < rn; i++) data.push_back(8'($urandom));
                write_txn(ra, rp, data);
            end else begin
                read_txn(ra, 1'($urandom_range(0, 1)), rp, rn);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regif.md
Name: i2c_slave_regif

Overview:
- Next-generation I2C slave that runs entirely in the CLK domain. SCL and SDA are oversampled, synchronised and deglitched; no logic is clocked on SCL.
- Supports multi-byte write and read bursts with an auto-incrementing register pointer, repeated START, and STOP detection in any state.
- Connects a serial I2C bus to a simple single-cycle register-file port (REG_*) that sits in front of a local register bank.

Parameters:
- REG_AW, 8, register pointer width; the pointer wraps modulo 2^REG_AW. Only the low REG_AW bits of the pointer byte are used.
- FILTER_LEN, 3, number of consecutive identical synchronised samples needed before filtered SCL/SDA change (range 1-15).

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous active-high reset
- SCL  input  1  I2C clock line
- SDA  inout  1  I2C data line, open-drain: driven 0 or released to z, never driven 1
- S_ADDR  input  7  slave address to match
- ADDR  output  7  last received 7-bit address (monitor)
- REG_ADDR  output  REG_AW  current register pointer
- REG_WDATA  output  8  write data byte
- REG_WE  output  1  one-CLK write strobe
- REG_RE  output  1  one-CLK read request
- REG_RDATA  input  8  read data, valid the CLK after REG_RE
- BUSY  output  1  high from address match until STOP, repeated START, or NACK release

Behaviour:
- Reset (sync, RST=1 at posedge CLK): state IDLE, SDA released, ADDR=0, REG_ADDR=0, REG_WDATA=0, REG_WE=0, REG_RE=0, BUSY=0, bit counter 0. Reset mid-transfer releases SDA on the next CLK edge.
- Input path: 2-FF synchroniser, then the FILTER_LEN stability filter, then a 1-cycle-delayed copy used for edge detection.
- Edge definitions on filtered signals: scl_rise, scl_fall; START = SDA falls while SCL high; STOP = SDA rises while SCL high.
- Timing requirement: SCL high and SCL low must each last at least FILTER_LEN+6 CLK.
- Priority: START > STOP > bit events. START in any state (including WAIT_STOP) goes to ADDR with bit counter 0. STOP in any state goes to IDLE, BUSY=0, SDA released.
- Bit sampling happens on scl_rise. SDA output changes only on the CLK after scl_fall.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first (7-bit address + R/W). After the 8th scl_rise, ADDR is updated. On match, BUSY=1 and go to ACK_A. On mismatch, go to WAIT_STOP and never drive SDA.
  - ACK_A: drive SDA=0 from the scl_fall after bit 8 until the next scl_fall. At that fall, go to PTR if W=0. If R=1, pulse REG_RE, load REG_RDATA the next CLK, and go to RD_DATA.
  - PTR: receive 8 bits, load REG_ADDR, then ACK_P (same ACK timing as ACK_A), then WR_DATA.
  - WR_DATA: receive 8 bits. On the 8th scl_rise, set REG_WDATA and pulse REG_WE for 1 CLK at the current REG_ADDR. Then ACK_W; REG_ADDR increments at the scl_fall ending ACK_W. Return to WR_DATA.
  - RD_DATA: shift out 8 bits MSB first (bit=0 drives 0, bit=1 releases). Release SDA at the scl_fall after bit 8, then go to RD_ACK.
  - RD_ACK: sample the master bit on scl_rise. REG_ADDR increments at the next scl_fall in both cases. If ACK (0), pulse REG_RE at that scl_fall and go to RD_DATA. If NACK (1), go to WAIT_STOP with BUSY=0.
  - WAIT_STOP: SDA released; leave only on STOP or START.
- The pointer persists across STOP and repeated START, so a write of the pointer followed by Sr + read reads from the written pointer.
- Wrap: REG_ADDR = 2^REG_AW-1 increments to 0.
- A write transaction with only the pointer byte (STOP after ACK_P) produces no REG_WE.
- Stray scl edges in IDLE are ignored.
- START or STOP in mid-byte aborts the byte: no REG_WE and no pointer increment.

Test Plan:
- Write burst: S_ADDR=7'h42, S 0x84 0x10 0xA5 0x5A P -> ACK on all 4 bytes; REG_WE at REG_ADDR 0x10 with 0xA5, then at 0x11 with 0x5A; BUSY 0 after P; REG_ADDR=0x12.
- Read with repeated start: S 0x84 0x20 Sr 0x85, regbank[0x20]=0x3C, [0x21]=0xC3, master ACK then NACK, P -> SDA bytes 0x3C, 0xC3; two REG_RE pulses; final REG_ADDR=0x22; SDA released after NACK.
- Address mismatch: S 0x86 0x10 0xFF P -> SDA never driven low by the slave, no REG_WE, BUSY stays 0, ADDR=0x43.
- Pointer wrap: write ptr 0xFF, data 0x11 0x22 -> REG_WE at 0xFF (0x11), then at 0x00 (0x22).
- Glitch and abort: 1-CLK SDA pulse while SCL high -> no START/STOP; STOP injected after 4 data bits -> no REG_WE, state IDLE.
- Reset mid-read: assert RST while the slave drives SDA=0 -> SDA=z on the next CLK, all outputs at reset values, next S 0x84 is ACKed normally.
